updown_counter_n: RTL and testbench

Parametrised synchronous up/down counter built from toggle cells, generalising the lab's 4-bit up/down counter. Adds a configurable width, a programmable modulus, wrap or saturate mode, count enable, parallel load, terminal-count output and a wrap/overflow pulse. It serves as the general-purpose counter for later lab designs such as timers, dividers and sequencers.

---
 rtl/udcnt_pkg.sv | 13 +
 rtl/t_cell_ar.sv | 34 +++
 rtl/updown_counter_n.sv | 113 +++++++++++
 tb/tb_updown_counter_n.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/udcnt_pkg.sv
// Shared constants for the up/down counter: direction and mode encodings
// and the default counter width.
package udcnt_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/t_cell_ar.sv
// Single-bit toggle cell: falling-edge flop with asynchronous active-low
// reset, synchronous load (dominant) and toggle enable.
module t_cell_ar (
    input  logic clk,
    input  logic rst_n,
    input  logic t_i,
    input  logic ld_i,
    input  logic ld_val_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (ld_i) begin
            q_d = ld_val_i;
        end else if (t_i) begin
            q_d = ~q_q;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/updown_counter_n.sv
// Parametrised falling-edge up/down counter built from toggle cells, with
// programmable modulus, wrap/saturate mode, terminal count and overflow pulse.
// Parallel load is compiled in only when UDCNT_LOAD_EN is defined.
module updown_counter_n
    import udcnt_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int MODULUS  = 2**WIDTH,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             x,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
    localparam bit               FULL_MOD = (MODULUS == (1 << WIDTH));
    localparam bit               SAT_MODE = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] q_cells;
    logic [WIDTH-1:0] ones_below;
    logic [WIDTH-1:0] zeros_below;
    logic [WIDTH-1:0] tog;
    logic [WIDTH-1:0] cell_ld_val;
    logic [WIDTH-1:0] wrap_val;
    logic [WIDTH-1:0] load_val;
    logic             cell_ld;
    logic             ext_ld;
    logic             at_end;
    logic             ovf_q;
    logic             ovf_d;

    assign at_end   = (x == DIR_UP) ? (q_cells == MAX_VAL) : (q_cells == '0);
    assign tc       = en & at_end;
    assign wrap_val = (x == DIR_UP) ? '0 : MAX_VAL;

`ifdef UDCNT_LOAD_EN
    assign ext_ld   = load;
    assign load_val = ({1'b0, d} >= MOD_EXT) ? MAX_VAL : d;
`else
    logic unused_load;
    assign ext_ld      = 1'b0;
    assign load_val    = '0;
    assign unused_load = ^{load, d};
`endif

    // Ripple conditions: bit k toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        ones_below     = '0;
        zeros_below    = '0;
        ones_below[0]  = 1'b1;
        zeros_below[0] = 1'b1;
        for (int k = 1; k < WIDTH; k++) begin
            ones_below[k]  = ones_below[k-1] & q_cells[k-1];
            zeros_below[k] = zeros_below[k-1] & ~q_cells[k-1];
        end
    end

    always_comb begin
        cell_ld     = 1'b0;
        cell_ld_val = '0;
        tog         = '0;
        if (ext_ld) begin
            cell_ld     = 1'b1;
            cell_ld_val = load_val;
        end else if (tc) begin
            // Boundary: saturate holds; a short modulus forces the wrap value.
            if (!SAT_MODE && !FULL_MOD) begin
                cell_ld     = 1'b1;
                cell_ld_val = wrap_val;
            end else if (!SAT_MODE) begin
                tog = '1;
            end
        end else if (en) begin
            tog = (x == DIR_UP) ? ones_below : zeros_below;
        end
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            t_cell_ar u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .t_i      (tog[i]),
                .ld_i     (cell_ld),
                .ld_val_i (cell_ld_val[i]),
                .q_o      (q_cells[i])
            );
        end
    endgenerate

    assign ovf_d = ext_ld ? 1'b0 : tc;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign Q   = q_cells;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed bench for updown_counter_n: three instances (mod-16 wrap,
// mod-10 wrap, mod-10 saturate) sharing clock and reset.
module tb_updown_counter_n;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [2:0]   en;
    logic [2:0]   x;
    logic [2:0]   load;
    logic [W-1:0] d [3];
    logic [W-1:0] q [3];
    logic [2:0]   tc;
    logic [2:0]   ovf;

    int n_tests;
    int n_fail;
    logic [W-1:0] exp_q[$];

    updown_counter_n #(.WIDTH(W), .MODULUS(16), .SATURATE(0)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .x(x[0]), .load(load[0]),
        .d(d[0]), .Q(q[0]), .tc(tc[0]), .ovf(ovf[0])
    );

    updown_counter_n #(.WIDTH(W), .MODULUS(10), .SATURATE(0)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .x(x[1]), .load(load[1]),
        .d(d[1]), .Q(q[1]), .tc(tc[1]), .ovf(ovf[1])
    );

    updown_counter_n #(.WIDTH(W), .MODULUS(10), .SATURATE(1)) u_sat10 (
        .clk(clk), .rst_n(rst_n), .en(en[2]), .x(x[2]), .load(load[2]),
        .d(d[2]), .Q(q[2]), .tc(tc[2]), .ovf(ovf[2])
    );

    // Clock: negedges at 10, 20, 30, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int u, input logic e, input logic dir, input logic ld,
                         input logic [W-1:0] dv);
        en[u]   = e;
        x[u]    = dir;
        load[u] = ld;
        d[u]    = dv;
    endtask

    task automatic check_q(input int u, input string tag);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check_eq(tag, {28'd0, q[u]}, {28'd0, e});
    endtask

    initial begin
        logic [W-1:0] e;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        for (int u = 0; u < 3; u++) drive(u, 1'b0, 1'b0, 1'b0, '0);

        // Reset state
        #3;
        for (int u = 0; u < 3; u++) begin
            check_eq("rst_q", {28'd0, q[u]}, 32'd0);
            check_eq("rst_ovf", {31'd0, ovf[u]}, 32'd0);
            check_eq("rst_tc", {31'd0, tc[u]}, 32'd0);
        end

        // Count up through wrap on the full-range counter
        drive(0, 1'b1, 1'b0, 1'b0, '0);
        #1;
        check_eq("up_tc_at0", {31'd0, tc[0]}, 32'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) exp_q.push_back(W'(k % 16));
        for (int k = 1; k <= 17; k++) begin
            e = exp_q[0];
            tick();
            check_q(0, "up16_q");
            check_eq("up16_tc", {31'd0, tc[0]}, {31'd0, (e == 4'd15)});
            check_eq("up16_ovf", {31'd0, ovf[0]}, {31'd0, (k == 16)});
        end
        drive(0, 1'b0, 1'b0, 1'b0, '0);

        // Down wrap with modulus 10
        drive(1, 1'b1, 1'b1, 1'b0, '0);
        #1;
        check_eq("dn10_tc_at0", {31'd0, tc[1]}, 32'd1);
        exp_q.push_back(4'd9);
        exp_q.push_back(4'd8);
        exp_q.push_back(4'd7);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_q(1, "dn10_q");
            check_eq("dn10_ovf", {31'd0, ovf[1]}, {31'd0, (k == 0)});
            check_eq("dn10_tc", {31'd0, tc[1]}, 32'd0);
        end
        drive(1, 1'b0, 1'b0, 1'b0, '0);

        // Saturate: climb to 8, then three more edges sit at 9
        drive(2, 1'b1, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 8; k++) exp_q.push_back(W'(k));
        for (int k = 0; k < 3; k++) exp_q.push_back(4'd9);
        for (int k = 0; k < 11; k++) begin
            tick();
            check_q(2, "sat_q");
            check_eq("sat_ovf", {31'd0, ovf[2]}, {31'd0, (k >= 9)});
        end
        check_eq("sat_tc", {31'd0, tc[2]}, 32'd1);
        drive(2, 1'b0, 1'b0, 1'b0, '0);
        #1;
        check_eq("sat_tc_en0", {31'd0, tc[2]}, 32'd0);
        tick();
        check_eq("sat_hold_q", {28'd0, q[2]}, 32'd9);
        check_eq("sat_hold_ovf", {31'd0, ovf[2]}, 32'd0);

        // Load priority and clamp on the mod-10 counter (currently 7)
        drive(1, 1'b1, 1'b0, 1'b1, 4'd12);
        tick();
`ifdef UDCNT_LOAD_EN
        check_eq("ld_clamp_q", {28'd0, q[1]}, 32'd9);
`else
        check_eq("ld_ign_q", {28'd0, q[1]}, 32'd8);
`endif
        check_eq("ld_clamp_ovf", {31'd0, ovf[1]}, 32'd0);
        drive(1, 1'b1, 1'b0, 1'b1, 4'd3);
        #1;
`ifdef UDCNT_LOAD_EN
        check_eq("ld_tc", {31'd0, tc[1]}, 32'd1);
        tick();
        check_eq("ld_val_q", {28'd0, q[1]}, 32'd3);
`else
        check_eq("ld_tc", {31'd0, tc[1]}, 32'd0);
        tick();
        check_eq("ld_ign_q2", {28'd0, q[1]}, 32'd9);
`endif
        check_eq("ld_ovf", {31'd0, ovf[1]}, 32'd0);
        drive(1, 1'b0, 1'b0, 1'b0, '0);

        // Asynchronous reset mid-count: bring the mod-16 counter from 1 to 7
        drive(0, 1'b1, 1'b0, 1'b0, '0);
        for (int k = 2; k <= 7; k++) exp_q.push_back(W'(k));
        for (int k = 0; k < 6; k++) begin
            tick();
            check_q(0, "pre_rst_q");
        end
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_q", {28'd0, q[0]}, 32'd0);
        check_eq("arst_ovf", {31'd0, ovf[0]}, 32'd0);
        check_eq("arst_sat_q", {28'd0, q[2]}, 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_q", {28'd0, q[0]}, 32'd1);
        drive(0, 1'b0, 1'b0, 1'b0, '0);

        // Direction change on the mod-10 counter (reset to 0): reach 5, then alternate
        drive(1, 1'b1, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 5; k++) exp_q.push_back(W'(k));
        for (int k = 0; k < 5; k++) begin
            tick();
            check_q(1, "dir_pre_q");
        end
        exp_q.push_back(4'd6);
        exp_q.push_back(4'd5);
        exp_q.push_back(4'd6);
        exp_q.push_back(4'd5);
        for (int k = 0; k < 4; k++) begin
            drive(1, 1'b1, (k % 2 == 1), 1'b0, '0);
            tick();
            check_q(1, "dir_alt_q");
        end
        drive(1, 1'b0, 1'b0, 1'b0, '0);
        #1;
        check_eq("en0_tc_up", {31'd0, tc[1]}, 32'd0);
        tick();
        check_eq("en0_hold_q", {28'd0, q[1]}, 32'd5);
        drive(1, 1'b0, 1'b1, 1'b0, '0);
        #1;
        check_eq("en0_tc_dn", {31'd0, tc[1]}, 32'd0);
        tick();
        check_eq("en0_hold_q2", {28'd0, q[1]}, 32'd5);
        check_eq("en0_ovf", {31'd0, ovf[1]}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
